// File: rtl/cam_pkg.sv
// Shared constants for the parametrised CAM: operation codes, encoder
// direction selectors and the index-width helper.
package cam_pkg;

  localparam logic [1:0] OP_IDLE = 2'd0;
  localparam logic [1:0] OP_SRCH = 2'd1;
  localparam logic [1:0] OP_WR   = 2'd2;
  localparam logic [1:0] OP_INV  = 2'd3;

  localparam int HIGH_FIRST = 0;
  localparam int LOW_FIRST  = 1;

  // Index width for n entries; never below one bit so a 2-entry CAM still
  // gets a usable address.
  function automatic int clog2w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/param_cam_if.sv
// Request/response bundle between a CAM client and param_cam.
interface param_cam_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) ();
  localparam int ADDR_W = cam_pkg::clog2w(DEPTH);

  logic              ren;
  logic              wen;
  logic              inv;
  logic              alloc;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] mask;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] dout;
  logic              hit;
  logic              multi;
  logic              wack;
  logic [ADDR_W-1:0] widx;
  logic              werr;
  logic              full;
  logic              empty;

  modport master (
    output ren, wen, inv, alloc, din, mask, addr,
    input  dout, hit, multi, wack, widx, werr, full, empty
  );

  modport slave (
    input  ren, wen, inv, alloc, din, mask, addr,
    output dout, hit, multi, wack, widx, werr, full, empty
  );
endinterface

// File: rtl/cam_prio_enc.sv
// Priority encoder: index of the highest or lowest set request bit, plus
// an any-set flag. Index is 0 when nothing is set.
module cam_prio_enc import cam_pkg::*; #(
  parameter int DEPTH  = 16,
  parameter int DIR    = HIGH_FIRST,
  parameter int ADDR_W = clog2w(DEPTH)
) (
  input  logic [DEPTH-1:0]  req,
  output logic [ADDR_W-1:0] idx,
  output logic              any
);

  // Scan so that the winning bit is the last one assigned.
  always_comb begin
    idx = '0;
    any = |req;
    if (DIR == HIGH_FIRST) begin
      for (int i = 0; i < DEPTH; i++)
        if (req[i]) idx = ADDR_W'(i);
    end else begin
      for (int i = DEPTH - 1; i >= 0; i--)
        if (req[i]) idx = ADDR_W'(i);
    end
  end

endmodule

// File: rtl/param_cam.sv
// Parametrised CAM with per-entry valid bits, masked search, invalidate,
// auto-allocating writes and multi/full/empty reporting. Search results
// and write acks are registered (latency 1).
module param_cam import cam_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  param_cam_if.slave  bus
);
  localparam int ADDR_W = clog2w(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [DEPTH-1:0]  match;
  logic [DEPTH-1:0]  free;
  logic [1:0]        op;
  logic [ADDR_W-1:0] hi_idx, free_idx, wr_idx;
  logic              hi_any, free_any, addr_ok, wr_ok, multi_c;

  logic [ADDR_W-1:0] dout_q, widx_q;
  logic              hit_q, multi_q, wack_q, werr_q;

  // Exactly one operation per cycle: search beats write beats invalidate.
  always_comb begin
    op = OP_IDLE;
    if (bus.ren)      op = OP_SRCH;
    else if (bus.wen) op = OP_WR;
    else if (bus.inv) op = OP_INV;
  end

  // Per-entry masked compare; invalid entries never match.
  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    assign match[g] = valid[g] & (((bus.din ^ mem[g]) & bus.mask) == '0);
  end

  assign free    = ~valid;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_c = |(match & (match - DEPTH'(1)));

  cam_prio_enc #(.DEPTH(DEPTH), .DIR(HIGH_FIRST), .ADDR_W(ADDR_W)) u_hit_enc (
    .req(match), .idx(hi_idx), .any(hi_any)
  );

  cam_prio_enc #(.DEPTH(DEPTH), .DIR(LOW_FIRST), .ADDR_W(ADDR_W)) u_free_enc (
    .req(free), .idx(free_idx), .any(free_any)
  );

  // Resolve write target: lowest free slot when allocating, else addr.
  always_comb begin
    addr_ok = ({1'b0, bus.addr} < DEPTH_L);
    wr_idx  = bus.alloc ? free_idx : bus.addr;
    wr_ok   = bus.alloc ? free_any : addr_ok;
  end

  // Key storage is deliberately not reset; valid bits gate its use.
  always_ff @(posedge clk) begin
    if (op == OP_WR && wr_ok)
      for (int i = 0; i < DEPTH; i++)
        if (wr_idx == ADDR_W'(i)) mem[i] <= bus.din;
  end

  // Valid bits: set on accepted write, cleared on in-range invalidate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else begin
      if (op == OP_WR && wr_ok)
        for (int i = 0; i < DEPTH; i++)
          if (wr_idx == ADDR_W'(i)) valid[i] <= 1'b1;
      if (op == OP_INV && addr_ok)
        for (int i = 0; i < DEPTH; i++)
          if (bus.addr == ADDR_W'(i)) valid[i] <= 1'b0;
    end
  end

  // Registered results; everything returns to 0 on cycles not using it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q  <= '0;
      hit_q   <= 1'b0;
      multi_q <= 1'b0;
      wack_q  <= 1'b0;
      werr_q  <= 1'b0;
      widx_q  <= '0;
    end else begin
      hit_q   <= (op == OP_SRCH) && hi_any;
      multi_q <= (op == OP_SRCH) && multi_c;
      dout_q  <= (op == OP_SRCH) ? hi_idx : '0;
      wack_q  <= (op == OP_WR) && wr_ok;
      werr_q  <= (op == OP_WR) && !wr_ok;
      widx_q  <= (op == OP_WR && wr_ok) ? wr_idx : '0;
    end
  end

  assign bus.dout  = dout_q;
  assign bus.hit   = hit_q;
  assign bus.multi = multi_q;
  assign bus.wack  = wack_q;
  assign bus.werr  = werr_q;
  assign bus.widx  = widx_q;
  assign bus.full  = &valid;
  assign bus.empty = ~|valid;

endmodule

// File: tb/tb_param_cam.sv
// Bench for param_cam: a 8x16 instance driven from a vector table and a
// 12x5 instance for the non-power-of-two depth corners.
module tb_param_cam;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  param_cam_if #(.DATA_W(8),  .DEPTH(16)) b1 ();
  param_cam_if #(.DATA_W(12), .DEPTH(5))  b2 ();

  param_cam #(.DATA_W(8),  .DEPTH(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  param_cam #(.DATA_W(12), .DEPTH(5))  dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

  // op = {ren,wen,inv,alloc}; flg = {hit,multi,wack,werr,full,empty}
  typedef struct {
    logic [3:0]  op;
    logic [11:0] din;
    logic [11:0] mask;
    logic [3:0]  addr;
    logic [5:0]  flg;
    logic [3:0]  dout;
    logic [3:0]  widx;
  } vec_t;

  vec_t tbl[$];
  vec_t tbl2[$];
  vec_t exp_q[$];
  int checks = 0;
  int failures = 0;

  function automatic vec_t v(input logic [3:0] op, input logic [11:0] din,
                             input logic [11:0] mask, input logic [3:0] addr,
                             input logic [5:0] flg, input logic [3:0] dout,
                             input logic [3:0] widx);
    vec_t r;
    r.op = op; r.din = din; r.mask = mask; r.addr = addr;
    r.flg = flg; r.dout = dout; r.widx = widx;
    return r;
  endfunction

  function automatic logic [13:0] pack_exp(input vec_t e);
    return {e.flg, e.dout, e.widx};
  endfunction

  function automatic logic [13:0] act1();
    return {b1.hit, b1.multi, b1.wack, b1.werr, b1.full, b1.empty, b1.dout, b1.widx};
  endfunction

  function automatic logic [13:0] act2();
    return {b2.hit, b2.multi, b2.wack, b2.werr, b2.full, b2.empty, 1'b0, b2.dout, 1'b0, b2.widx};
  endfunction

  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got flags=%06b dout=%0d widx=%0d want flags=%06b dout=%0d widx=%0d",
               name, act[13:8], act[7:4], act[3:0], exp[13:8], exp[7:4], exp[3:0]);
    end
  endtask

  task automatic drive(input vec_t x, input bit sel);
    if (!sel) begin
      {b1.ren, b1.wen, b1.inv, b1.alloc} = x.op;
      b1.din = x.din[7:0]; b1.mask = x.mask[7:0]; b1.addr = x.addr;
    end else begin
      {b2.ren, b2.wen, b2.inv, b2.alloc} = x.op;
      b2.din = x.din; b2.mask = x.mask; b2.addr = x.addr[2:0];
    end
  endtask

  // Drive one vector, queue its expectation, compare after the edge.
  task automatic apply(input vec_t x, input bit sel, input string name);
    vec_t e;
    drive(x, sel);
    exp_q.push_back(x);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    chk(name, sel ? act2() : act1(), pack_exp(e));
  endtask

  task automatic idle_all();
    vec_t z;
    z = v(4'b0000, 0, 0, 0, 0, 0, 0);
    drive(z, 1'b0);
    drive(z, 1'b1);
  endtask

  initial begin
    idle_all();
    repeat (2) @(posedge clk);
    #1;
    chk("reset1", act1(), {6'b000001, 4'd0, 4'd0});
    chk("reset2", act2(), {6'b000001, 4'd0, 4'd0});
    rst_n = 1'b1;

    // Mid-cycle reset with a search in flight.
    apply(v(4'b0100, 'hA5, 0, 3, 6'b001000, 0, 3), 0, "pre_rst_wr");
    apply(v(4'b1000, 'hA5, 'hFF, 0, 6'b100000, 3, 0), 0, "pre_rst_srch");
    drive(v(4'b1000, 'hA5, 'hFF, 0, 0, 0, 0), 0);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", act1(), {6'b000001, 4'd0, 4'd0});
    @(posedge clk); #1;
    chk("rst_inflight", act1(), {6'b000001, 4'd0, 4'd0});
    idle_all();
    rst_n = 1'b1;

    // Main table for the 8x16 instance.
    tbl.push_back(v(4'b1000, 'h00, 'hFF, 0, 6'b000001, 0, 0));
    tbl.push_back(v(4'b0100, 'hA5, 0, 3, 6'b001000, 0, 3));
    tbl.push_back(v(4'b0100, 'hA5, 0, 9, 6'b001000, 0, 9));
    tbl.push_back(v(4'b1000, 'hA5, 'hFF, 0, 6'b110000, 9, 0));
    tbl.push_back(v(4'b0100, 'hA0, 0, 5, 6'b001000, 0, 5));
    tbl.push_back(v(4'b0010, 0, 0, 9, 6'b000000, 0, 0));
    tbl.push_back(v(4'b1000, 'hAF, 'hF0, 0, 6'b110000, 5, 0));
    tbl.push_back(v(4'b1000, 'hAF, 'hFF, 0, 6'b000000, 0, 0));
    tbl.push_back(v(4'b1000, 'hA5, 'h00, 0, 6'b110000, 5, 0));
    tbl.push_back(v(4'b1000, 'hA0, 'hFF, 0, 6'b100000, 5, 0));
    tbl.push_back(v(4'b1000, 'hA5, 'hFF, 0, 6'b100000, 3, 0));
    tbl.push_back(v(4'b0010, 0, 0, 3, 6'b000000, 0, 0));
    tbl.push_back(v(4'b0010, 0, 0, 5, 6'b000001, 0, 0));
    tbl.push_back(v(4'b1000, 'hA5, 'h00, 0, 6'b000001, 0, 0));
    for (int i = 0; i < 16; i++)
      tbl.push_back(v(4'b0101, 12'h10 + 12'(i), 0, 15,
                      {2'b00, 1'b1, 1'b0, (i == 15), 1'b0}, 0, 4'(i)));
    tbl.push_back(v(4'b0101, 'hEE, 0, 0, 6'b000110, 0, 0));
    tbl.push_back(v(4'b1000, 'hEE, 'hFF, 0, 6'b000010, 0, 0));
    tbl.push_back(v(4'b1000, 'h1F, 'hFF, 0, 6'b100010, 15, 0));
    tbl.push_back(v(4'b1000, 'h10, 'hF0, 0, 6'b110010, 15, 0));
    tbl.push_back(v(4'b0010, 0, 0, 7, 6'b000000, 0, 0));
    tbl.push_back(v(4'b0101, 'h77, 0, 0, 6'b001010, 0, 7));
    tbl.push_back(v(4'b1000, 'h77, 'hFF, 0, 6'b100010, 7, 0));
    tbl.push_back(v(4'b1110, 'h12, 'hFF, 0, 6'b100010, 2, 0));
    tbl.push_back(v(4'b1000, 'h10, 'hFF, 0, 6'b100010, 0, 0));
    tbl.push_back(v(4'b1000, 'h12, 'hFF, 0, 6'b100010, 2, 0));
    tbl.push_back(v(4'b0110, 'h55, 0, 0, 6'b001010, 0, 0));
    tbl.push_back(v(4'b1000, 'h55, 'hFF, 0, 6'b100010, 0, 0));
    tbl.push_back(v(4'b1000, 'h10, 'hFF, 0, 6'b000010, 0, 0));
    tbl.push_back(v(4'b0000, 'h55, 'hFF, 0, 6'b000010, 0, 0));
    tbl.push_back(v(4'b0111, 'h66, 0, 0, 6'b000110, 0, 0));
    foreach (tbl[i]) apply(tbl[i], 0, $sformatf("t1_%0d", i));
    idle_all();

    // 12x5 instance: out-of-range addresses and non-power-of-two fill.
    tbl2.push_back(v(4'b0100, 'hABC, 0, 6, 6'b000101, 0, 0));
    tbl2.push_back(v(4'b0100, 'hABC, 0, 5, 6'b000101, 0, 0));
    for (int i = 0; i < 5; i++)
      tbl2.push_back(v(4'b0101, 12'hAB0 + 12'(i), 0, 7,
                       {2'b00, 1'b1, 1'b0, (i == 4), 1'b0}, 0, 4'(i)));
    tbl2.push_back(v(4'b1000, 'hAB0, 'hFF0, 0, 6'b110010, 4, 0));
    tbl2.push_back(v(4'b1000, 'hAB2, 'hFFF, 0, 6'b100010, 2, 0));
    tbl2.push_back(v(4'b0101, 'h123, 0, 0, 6'b000110, 0, 0));
    tbl2.push_back(v(4'b0010, 0, 0, 6, 6'b000010, 0, 0));
    tbl2.push_back(v(4'b0010, 0, 0, 4, 6'b000000, 0, 0));
    tbl2.push_back(v(4'b1000, 'hAB0, 'hFF0, 0, 6'b110000, 3, 0));
    tbl2.push_back(v(4'b0100, 'hFFF, 0, 4, 6'b001010, 0, 4));
    tbl2.push_back(v(4'b1000, 'hFFF, 'hFFF, 0, 6'b100010, 4, 0));
    foreach (tbl2[i]) apply(tbl2[i], 1, $sformatf("t2_%0d", i));
    idle_all();

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
